// File: rtl/spi_master_feeder.sv
// Job sequencer in front of the spi_top master: queues (req, byte) jobs, runs them one
// at a time with an idle gap between jobs, returns received bytes, and aborts hung transfers.
module spi_master_feeder #(
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 8,
  parameter int GAP_CYCLES  = 10,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [1:0]               wr_req,
  input  logic [DATA_W-1:0]        wr_data,
  output logic [1:0]               req,
  output logic [DATA_W-1:0]        din_master,
  input  logic                     done_tx,
  input  logic                     done_rx,
  input  logic [DATA_W-1:0]        dout_master,
  output logic                     rx_valid,
  input  logic                     rx_ready,
  output logic [DATA_W-1:0]        rx_data,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     busy,
  output logic                     timeout_err,
  input  logic                     err_clr
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, GAP} state_t;

  state_t            state_q, state_d;
  logic [1:0]        fifo_req  [DEPTH];
  logic [DATA_W-1:0] fifo_data [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [TW-1:0]     timer;
  logic [GW-1:0]     gap_cnt;
  logic              got_tx, got_rx;

  logic              push, launch, finish, abort, capture;
  logic              can_launch, tx_ok, rx_ok, job_done, timer_end, gap_end;
  logic [1:0]        head_req;
  logic [DATA_W-1:0] head_data;

  assign wr_ready   = !rst && (fifo_level < LW'(DEPTH));
  // req code 0 is a no-op job: the handshake completes but nothing is queued
  assign push       = wr_valid && wr_ready && (wr_req != 2'd0);
  assign head_req   = fifo_req[rd_ptr];
  assign head_data  = fifo_data[rd_ptr];
  // an rx job must not start while the previous received byte is still unread
  assign can_launch = (fifo_level != '0) && !(head_req[1] && rx_valid);
  assign tx_ok      = got_tx || done_tx;
  assign rx_ok      = got_rx || done_rx;
  assign job_done   = (!req[0] || tx_ok) && (!req[1] || rx_ok);
  assign timer_end  = (timer == TW'(TIMEOUT_CYC - 1));
  assign gap_end    = (gap_cnt == GW'(GAP_CYCLES - 1));
  assign busy       = (state_q != IDLE) || (fifo_level != '0);

  always_comb begin
    state_d = state_q;
    launch  = 1'b0;
    finish  = 1'b0;
    abort   = 1'b0;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (can_launch) begin
          launch  = 1'b1;
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        capture = done_rx && req[1] && !got_rx;
        if (job_done) begin
          finish  = 1'b1;
          state_d = GAP;
        end else if (timer_end) begin
          abort   = 1'b1;
          state_d = GAP;
        end
      end
      GAP: begin
        // launching straight from the last gap cycle keeps the idle gap at exactly GAP_CYCLES
        if (gap_end) begin
          if (can_launch) begin
            launch  = 1'b1;
            state_d = ACTIVE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_req[wr_ptr]  <= wr_req;
      fifo_data[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      req         <= 2'd0;
      din_master  <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_level  <= '0;
      timer       <= '0;
      gap_cnt     <= '0;
      got_tx      <= 1'b0;
      got_rx      <= 1'b0;
      rx_valid    <= 1'b0;
      rx_data     <= '0;
      timeout_err <= 1'b0;
    end else begin
      state_q    <= state_d;
      fifo_level <= fifo_level + LW'(push) - LW'(launch);
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (launch) begin
        rd_ptr     <= rd_ptr + 1'b1;
        req        <= head_req;
        din_master <= head_data;
        got_tx     <= 1'b0;
        got_rx     <= 1'b0;
        timer      <= '0;
      end else if (state_q == ACTIVE) begin
        got_tx <= tx_ok;
        got_rx <= rx_ok;
        if (finish || abort) begin
          req     <= 2'd0;
          gap_cnt <= '0;
        end else begin
          timer <= timer + 1'b1;
        end
      end else if (state_q == GAP) begin
        gap_cnt <= gap_cnt + 1'b1;
      end
      if (capture) begin
        rx_valid <= 1'b1;
        rx_data  <= dout_master;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
      if (abort) timeout_err <= 1'b1;
      else if (err_clr) timeout_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_master_feeder.sv
// Directed bench for spi_master_feeder: a job-level reference model compared every cycle,
// plus hand-computed checks on latency, gap length, FIFO full, timeout and reset.
module tb_spi_master_feeder;

  localparam int DEPTH = 8;
  localparam int GAP   = 10;
  localparam int TMO   = 4096;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [1:0] wr_req = 2'd0;
  logic [7:0] wr_data = 8'd0;
  logic [1:0] req;
  logic [7:0] din_master;
  logic       done_tx = 1'b0;
  logic       done_rx = 1'b0;
  logic [7:0] dout_master = 8'd0;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic [3:0] fifo_level;
  logic       busy;
  logic       timeout_err;
  logic       err_clr = 1'b0;

  int total = 0;
  int bad   = 0;

  spi_master_feeder #(.DATA_W(8), .DEPTH(DEPTH), .GAP_CYCLES(GAP), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_req(wr_req),
    .wr_data(wr_data), .req(req), .din_master(din_master), .done_tx(done_tx),
    .done_rx(done_rx), .dout_master(dout_master), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_data(rx_data), .fifo_level(fifo_level), .busy(busy), .timeout_err(timeout_err),
    .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  // Reference model: queue of pending jobs, the running job, gap countdown, rx slot.
  typedef struct packed {
    logic [1:0] r;
    logic [7:0] d;
  } job_t;

  job_t       mq[$];
  bit         m_on = 1'b0;
  bit         m_act = 1'b0;
  job_t       m_job;
  int         m_acnt = 0;
  bit         m_gtx = 1'b0;
  bit         m_grx = 1'b0;
  int         m_gap = 0;
  logic [7:0] m_din = 8'd0;
  logic       m_rxv = 1'b0;
  logic [7:0] m_rxd = 8'd0;
  logic       m_terr = 1'b0;

  always @(negedge clk) begin
    logic [25:0] e, a;
    bit   launch, acc, abort, tx, rx;
    job_t hd;
    if (m_on) begin
      e = {(!rst && (mq.size() < DEPTH)), (m_act ? m_job.r : 2'd0), m_din, m_rxv, m_rxd,
           4'(mq.size()), (m_act || (m_gap > 0) || (mq.size() > 0)), m_terr};
      a = {wr_ready, req, din_master, rx_valid, rx_data, fifo_level, busy, timeout_err};
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL model t=%0t outputs {wr_ready,req,din,rx_valid,rx_data,level,busy,terr}: got %h expected %h",
                 $time, a, e);
      end
    end
    if (rst) begin
      mq.delete();
      m_act = 1'b0; m_gap = 0; m_din = 8'd0; m_rxv = 1'b0; m_rxd = 8'd0; m_terr = 1'b0;
      m_on = 1'b1;
    end else if (m_on) begin
      launch = !m_act && (m_gap <= 1) && (mq.size() > 0);
      if (launch) launch = !(mq[0].r[1] && m_rxv);
      acc   = wr_valid && (wr_req != 2'd0) && (mq.size() < DEPTH);
      abort = 1'b0;
      if (m_rxv && rx_ready) m_rxv = 1'b0;
      if (m_act) begin
        if (done_rx && m_job.r[1] && !m_grx) begin
          m_rxv = 1'b1;
          m_rxd = dout_master;
        end
        tx = m_gtx || done_tx;
        rx = m_grx || done_rx;
        m_gtx = tx;
        m_grx = rx;
        m_acnt++;
        if ((!m_job.r[0] || tx) && (!m_job.r[1] || rx)) begin
          m_act = 1'b0; m_gap = GAP;
        end else if (m_acnt == TMO) begin
          m_act = 1'b0; m_gap = GAP; abort = 1'b1;
        end
      end else if (launch) begin
        hd = mq.pop_front();
        m_act = 1'b1; m_job = hd; m_din = hd.d; m_acnt = 0;
        m_gtx = 1'b0; m_grx = 1'b0; m_gap = 0;
      end else if (m_gap > 0) begin
        m_gap--;
      end
      if (acc) begin
        hd.r = wr_req;
        hd.d = wr_data;
        mq.push_back(hd);
      end
      if (abort) m_terr = 1'b1;
      else if (err_clr) m_terr = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push1(input logic [1:0] r, input logic [7:0] d);
    wr_valid = 1'b1; wr_req = r; wr_data = d;
    tick();
    wr_valid = 1'b0; wr_req = 2'd0;
  endtask

  task automatic wait_req(input string nm);
    int n = 0;
    while (req == 2'd0 && n < 200) begin
      tick();
      n++;
    end
    chk(nm, 32'(req != 2'd0), 1);
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    chk(nm, 32'(busy), 0);
  endtask

  task automatic consume_rx();
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
  endtask

  initial begin
    int n;
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) tick();
    chk("reset wr_ready", 32'(wr_ready), 0);
    chk("reset req", 32'(req), 0);
    chk("reset din", 32'(din_master), 0);
    chk("reset level", 32'(fifo_level), 0);
    chk("reset busy", 32'(busy), 0);
    chk("reset rx_valid", 32'(rx_valid), 0);
    chk("reset terr", 32'(timeout_err), 0);
    rst = 1'b0;
    #1;
    chk("wr_ready after reset", 32'(wr_ready), 1);

    // T1: tx job, launch latency, completion on done_tx, gap length
    tick();
    push1(2'd1, 8'hA5);
    chk("T1 level N+1", 32'(fifo_level), 1);
    chk("T1 req N+1", 32'(req), 0);
    tick();
    chk("T1 req N+2", 32'(req), 1);
    chk("T1 din N+2", 32'(din_master), 'hA5);
    tick();
    push1(2'd3, 8'h5A);
    repeat (17) tick();
    done_tx = 1'b1;
    chk("T1 req at done_tx", 32'(req), 1);
    tick();
    done_tx = 1'b0;
    chk("T1 req after done", 32'(req), 0);
    chk("T1 din held", 32'(din_master), 'hA5);
    n = 0;
    while (req == 2'd0 && n < 200) begin
      n++;
      tick();
    end
    chk("T1 gap cycles", 32'(n), GAP);
    chk("T1 job2 req", 32'(req), 3);
    chk("T1 job2 din", 32'(din_master), 'h5A);

    // T3: full duplex, rx first then tx five cycles later
    repeat (2) tick();
    done_rx = 1'b1; dout_master = 8'h77;
    tick();
    done_rx = 1'b0;
    chk("T3 still active after rx", 32'(req), 3);
    repeat (4) tick();
    done_tx = 1'b1;
    chk("T3 active at done_tx", 32'(req), 3);
    tick();
    done_tx = 1'b0;
    chk("T3 req after both", 32'(req), 0);
    chk("T3 rx_valid", 32'(rx_valid), 1);
    chk("T3 rx_data", 32'(rx_data), 'h77);
    consume_rx();
    chk("T3 rx_valid cleared", 32'(rx_valid), 0);
    // both strobes in the same cycle
    push1(2'd3, 8'h96);
    wait_req("T3b start");
    chk("T3b din", 32'(din_master), 'h96);
    repeat (2) tick();
    done_tx = 1'b1; done_rx = 1'b1; dout_master = 8'hE1;
    tick();
    done_tx = 1'b0; done_rx = 1'b0;
    chk("T3b req after same-cycle", 32'(req), 0);
    chk("T3b rx_data", 32'(rx_data), 'hE1);
    consume_rx();

    // T2: rx jobs; second one stalls while rx byte unread
    push1(2'd2, 8'h00);
    push1(2'd2, 8'hFF);
    wait_req("T2 start");
    chk("T2 req", 32'(req), 2);
    repeat (3) tick();
    done_rx = 1'b1; dout_master = 8'h3C;
    tick();
    done_rx = 1'b0;
    chk("T2 req after rx", 32'(req), 0);
    chk("T2 rx_valid", 32'(rx_valid), 1);
    chk("T2 rx_data", 32'(rx_data), 'h3C);
    repeat (30) tick();
    chk("T2 stalled req", 32'(req), 0);
    chk("T2 stalled level", 32'(fifo_level), 1);
    chk("T2 rx_data kept", 32'(rx_data), 'h3C);
    consume_rx();
    wait_req("T2 second start");
    chk("T2 second req", 32'(req), 2);
    tick();
    done_rx = 1'b1; dout_master = 8'h5B;
    tick();
    done_rx = 1'b0;
    chk("T2 second rx_data", 32'(rx_data), 'h5B);
    consume_rx();

    // T4: block the FIFO behind an unread rx byte and overfill it
    push1(2'd2, 8'h5A);
    wait_req("T4 prep start");
    done_rx = 1'b1; dout_master = 8'h99;
    tick();
    done_rx = 1'b0;
    wait_idle("T4 idle");
    push1(2'd0, 8'hAA);
    chk("T4 req0 not stored", 32'(fifo_level), 0);
    for (int i = 0; i < 9; i++) begin
      wr_valid = 1'b1; wr_req = 2'd2; wr_data = 8'(i);
      chk("T4 wr_ready", 32'(wr_ready), (i == 8) ? 0 : 1);
      tick();
    end
    wr_valid = 1'b0; wr_req = 2'd0;
    chk("T4 level full", 32'(fifo_level), 8);
    chk("T4 no launch", 32'(req), 0);
    chk("T4 busy", 32'(busy), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("T4 reset level", 32'(fifo_level), 0);
    chk("T4 reset rx_valid", 32'(rx_valid), 0);

    // T5: timeout, sticky error, set wins over clear
    push1(2'd1, 8'h11);
    wait_req("T5 start");
    n = 0;
    while (req != 2'd0 && n < 5000) begin
      n++;
      tick();
    end
    chk("T5 active cycles", 32'(n), TMO);
    chk("T5 terr set", 32'(timeout_err), 1);
    repeat (3) tick();
    chk("T5 terr sticky", 32'(timeout_err), 1);
    push1(2'd1, 8'h22);
    wait_req("T5b start");
    err_clr = 1'b1;
    tick();
    chk("T5b terr cleared", 32'(timeout_err), 0);
    n = 1;
    while (req != 2'd0 && n < 5000) begin
      n++;
      tick();
    end
    chk("T5b active cycles", 32'(n), TMO);
    chk("T5b set wins", 32'(timeout_err), 1);
    tick();
    chk("T5b clear after", 32'(timeout_err), 0);
    err_clr = 1'b0;
    push1(2'd1, 8'h33);
    wait_req("T5c start");
    chk("T5c din", 32'(din_master), 'h33);
    done_tx = 1'b1;
    tick();
    done_tx = 1'b0;
    chk("T5c done", 32'(req), 0);
    chk("T5c terr", 32'(timeout_err), 0);

    // T6: reset in the middle of an active job with queued work and an unread byte
    push1(2'd3, 8'h44);
    push1(2'd1, 8'h55);
    wait_req("T6 start");
    chk("T6 req", 32'(req), 3);
    repeat (2) tick();
    done_rx = 1'b1; dout_master = 8'h12;
    tick();
    done_rx = 1'b0;
    chk("T6 rx_valid before rst", 32'(rx_valid), 1);
    chk("T6 active before rst", 32'(req), 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("T6 req", 32'(req), 0);
    chk("T6 level", 32'(fifo_level), 0);
    chk("T6 rx_valid", 32'(rx_valid), 0);
    chk("T6 din", 32'(din_master), 0);
    chk("T6 busy", 32'(busy), 0);
    push1(2'd1, 8'h66);
    wait_req("T6 after rst start");
    chk("T6 after rst din", 32'(din_master), 'h66);
    done_tx = 1'b1;
    tick();
    done_tx = 1'b0;
    wait_idle("T6 final idle");

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
